collision_matrix_detector: RTL

Parametrised successor of the per-pair collision detection logic in the pinball video path. Takes N_LAYERS "draw" qualifiers from the object renderers. For every enabled layer pair, it emits a single-cycle first-hit pulse per frame. Adds behaviour the fixed detector lacks: a per-pair multi-frame cooldown, a frame-latched hit summary and a combined any-hit pulse. Sits between the object drawers and the game-control/score logic.

---
 rtl/collision_pkg.sv | 52 +++++
 rtl/collision_pair_tracker.sv | 83 ++++++++
 rtl/collision_matrix_detector.sv | 75 +++++++
 3 files changed

// File: rtl/collision_pkg.sv
// Shared constants and pair-index helpers for the collision matrix detector.
package collision_pkg;

  localparam int CD_W = 4;

  // Pinball layer map, used to build PAIR_MASK values
  localparam int LAYER_BALL     = 0;
  localparam int LAYER_FRAME    = 1;
  localparam int LAYER_FLIPPER  = 2;
  localparam int LAYER_OBSTACLE = 3;

  function automatic int npairs(input int n);
    return n * (n - 1) / 2;
  endfunction

  function automatic int pair_a(input int n, input int p);
    int idx;
    idx = 0;
    for (int a = 0; a < n; a++) begin
      for (int b = a + 1; b < n; b++) begin
        if (idx == p) return a;
        idx++;
      end
    end
    return 0;
  endfunction

  function automatic int pair_b(input int n, input int p);
    int idx;
    idx = 0;
    for (int a = 0; a < n; a++) begin
      for (int b = a + 1; b < n; b++) begin
        if (idx == p) return b;
        idx++;
      end
    end
    return 1;
  endfunction

  function automatic int pair_index(input int n, input int a, input int b);
    int idx;
    idx = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = i + 1; j < n; j++) begin
        if (i == a && j == b) return idx;
        idx++;
      end
    end
    return 0;
  endfunction

endpackage

// File: rtl/collision_pair_tracker.sv
// Per-pair state: first-hit flag, raw overlap, cooldown and, with
// COLLISION_OVERLAP_COUNT_EN, a saturating per-frame overlap counter.
module collision_pair_tracker
  import collision_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 0,
  parameter int CNT_W           = 12
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             ov,
  output logic             pulse,
  output logic             raw,
  output logic [CNT_W-1:0] count
);

  logic            seen_q, seen_d;
  logic            raw_q, raw_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            cd_zero;

  // seen only records cycles where a pulse was allowed, so at the frame
  // boundary it tells whether this pair actually pulsed in the ending frame
  always_comb begin
    cd_zero = (cd_q == '0);
    pulse   = ov && (startOfFrame || !seen_q) && cd_zero;
    seen_d  = (startOfFrame ? 1'b0 : seen_q) | (ov & cd_zero);
    raw_d   = (startOfFrame ? 1'b0 : raw_q) | ov;
    cd_d    = cd_q;
    if (startOfFrame) begin
      if (seen_q)
        cd_d = CD_W'(COOLDOWN_FRAMES);
      else if (!cd_zero)
        cd_d = cd_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      seen_q <= 1'b0;
      raw_q  <= 1'b0;
      cd_q   <= '0;
    end else begin
      seen_q <= seen_d;
      raw_q  <= raw_d;
      cd_q   <= cd_d;
    end
  end

  assign raw = raw_q;

`ifdef COLLISION_OVERLAP_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (startOfFrame) begin
      frame_cnt_d = cnt_q;
      cnt_d       = {{(CNT_W-1){1'b0}}, ov};
    end else if (ov && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign count = frame_cnt_q;
`else
  assign count = '0;
`endif

endmodule

// File: rtl/collision_matrix_detector.sv
// Per-layer-pair collision detector with cooldown and frame hit summary.
// Optional overlap counting is enabled by defining COLLISION_OVERLAP_COUNT_EN.
module collision_matrix_detector
  import collision_pkg::*;
#(
  parameter int                 N_LAYERS        = 4,
  parameter int                 N_PAIRS         = npairs(N_LAYERS),
  parameter logic [N_PAIRS-1:0] PAIR_MASK       = '1,
  parameter int                 COOLDOWN_FRAMES = 0,
  parameter int                 CNT_W           = 12
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic [N_LAYERS-1:0]      draw,
  output logic [N_PAIRS-1:0]       collisionPulse,
  output logic                     anyCollisionPulse,
  output logic [N_PAIRS-1:0]       frameHits,
  output logic                     frameHitsValid,
  output logic [N_PAIRS*CNT_W-1:0] overlapCount
);

  logic [N_PAIRS-1:0] pulse_w;
  logic [N_PAIRS-1:0] raw_w;
  logic [N_PAIRS-1:0] frame_hits_q, frame_hits_d;
  logic               frame_hits_valid_q, frame_hits_valid_d;

  for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
    localparam int A = pair_a(N_LAYERS, p);
    localparam int B = pair_b(N_LAYERS, p);
    if (PAIR_MASK[p]) begin : g_on
      logic ov;
      assign ov = draw[A] & draw[B];
      collision_pair_tracker #(
        .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
        .CNT_W          (CNT_W)
      ) u_trk (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .ov          (ov),
        .pulse       (pulse_w[p]),
        .raw         (raw_w[p]),
        .count       (overlapCount[p*CNT_W +: CNT_W])
      );
    end else begin : g_off
      assign pulse_w[p] = 1'b0;
      assign raw_w[p]   = 1'b0;
      assign overlapCount[p*CNT_W +: CNT_W] = '0;
    end
  end

  // The pulse path is combinational from draw, so hold it low while in reset
  assign collisionPulse    = pulse_w & {N_PAIRS{resetN}};
  assign anyCollisionPulse = |collisionPulse;

  always_comb begin
    frame_hits_d       = startOfFrame ? raw_w : frame_hits_q;
    frame_hits_valid_d = startOfFrame;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_hits_q       <= '0;
      frame_hits_valid_q <= 1'b0;
    end else begin
      frame_hits_q       <= frame_hits_d;
      frame_hits_valid_q <= frame_hits_valid_d;
    end
  end

  assign frameHits      = frame_hits_q;
  assign frameHitsValid = frame_hits_valid_q;

endmodule
